// File: rtl/acf_axi_pkg.sv
// rtl/acf_axi_pkg.sv - shared definitions for the ACF frame path (core, register block, frame reader)
package acf_axi_pkg;

  localparam int AXIS_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_READ,
    ST_LO,
    ST_HI,
    ST_DONE
  } acf_rd_state_t;

  // Photon count word followed by BIN_SIZE elements for each of NUM_BINS+1 bin blocks.
  function automatic int acf_frame_words(input int binSize, input int numBins);
    return 1 + binSize * (numBins + 1);
  endfunction

endpackage

// File: rtl/acf_frame_reader.sv
// rtl/acf_frame_reader.sv - drains one ACF frame from a standard FIFO into 32-bit AXI-Stream beats
module acf_frame_reader
  import acf_axi_pkg::*;
#(
  parameter int BIN_SIZE       = 8,
  parameter int NUM_BINS       = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    initTx,
  input  logic [NUM_BINS+32:0]    fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rdEn,
  output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic [31:0]             frameCount,
  output logic                    timeoutErr
);

  localparam int W           = NUM_BINS + 33;
  localparam int FRAME_WORDS = acf_frame_words(BIN_SIZE, NUM_BINS);
  localparam int IDX_W       = $clog2(FRAME_WORDS + 1);
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES + 1);

  acf_rd_state_t   state, stateNext;
  logic [W-1:0]    wordReg;
  logic [IDX_W-1:0] wordIdx;
  logic [TO_W-1:0] timeoutCnt;
  logic            dataPending;
  logic            isLastWord;
  logic            timeoutHit;
  logic [31:0]     loWord;

  assign isLastWord = (wordIdx == IDX_W'(FRAME_WORDS - 1));
  assign timeoutHit = (timeoutCnt == TO_W'(TIMEOUT_CYCLES - 1));
  // The popped word only lands in wordReg at the end of the first LO cycle, so that cycle forwards it.
  assign loWord     = dataPending ? fifo_dout[31:0] : wordReg[31:0];

  always_comb begin
    stateNext     = state;
    initTx        = 1'b0;
    fifo_rdEn     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) stateNext = ST_TRIG;
      end
      ST_TRIG: begin
        initTx    = 1'b1;
        stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (!fifo_empty)     stateNext = ST_READ;
        else if (timeoutHit) stateNext = ST_IDLE;
      end
      ST_READ: begin
        fifo_rdEn = 1'b1;
        stateNext = ST_LO;
      end
      ST_LO: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = loWord;
        if (m_axis_tready) stateNext = ST_HI;
      end
      ST_HI: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = AXIS_WIDTH'(wordReg[W-1:32]);
        m_axis_tlast  = isLastWord;
        if (m_axis_tready) stateNext = isLastWord ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        busy      = 1'b0;
        stateNext = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wordReg     <= '0;
      wordIdx     <= '0;
      timeoutCnt  <= '0;
      dataPending <= 1'b0;
      frameCount  <= '0;
      timeoutErr  <= 1'b0;
    end else begin
      state       <= stateNext;
      dataPending <= fifo_rdEn;
      if (dataPending) wordReg <= fifo_dout;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wordIdx    <= '0;
            timeoutCnt <= '0;
            timeoutErr <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Counting only here keeps downstream backpressure from ever aborting a frame.
          if (!fifo_empty) begin
            timeoutCnt <= '0;
          end else if (timeoutHit) begin
            timeoutCnt <= '0;
            timeoutErr <= 1'b1;
          end else begin
            timeoutCnt <= timeoutCnt + TO_W'(1);
          end
        end
        ST_HI: begin
          if (m_axis_tready && !isLastWord) wordIdx <= wordIdx + IDX_W'(1);
        end
        ST_DONE: frameCount <= frameCount + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acf_frame_reader.sv
// tb/tb_acf_frame_reader.sv - directed self-checking bench for acf_frame_reader with a behavioural FIFO
module tb_acf_frame_reader;

  localparam int W      = 53;
  localparam int NWORDS = 169;

  logic          clk;
  logic          rst;
  logic          start;
  logic          initTx;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          fifo_rdEn;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic [31:0]   frameCount;
  logic          timeoutErr;

  acf_frame_reader #(
    .BIN_SIZE(8),
    .NUM_BINS(20),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .initTx(initTx),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rdEn(fifo_rdEn),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .frameCount(frameCount),
    .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun;
  int testsFailed;

  // Behavioural non-FWFT FIFO plus a producer that pushes srcWords at a configurable rate.
  logic [W-1:0] srcWords [0:255];
  logic [W-1:0] fifoQ [$];
  int           feedTotal;
  int           feedPeriod;
  int           feedIdx;
  int           cyc;
  logic         feedRestart;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || feedRestart) begin
      fifoQ.delete();
      feedIdx    <= 0;
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rdEn && fifoQ.size() > 0) fifo_dout <= fifoQ.pop_front();
      if (feedIdx < feedTotal && (cyc % feedPeriod) == 0) begin
        fifoQ.push_back(srcWords[feedIdx]);
        feedIdx <= feedIdx + 1;
      end
      fifo_empty <= (fifoQ.size() == 0);
    end
  end

  // Stream sink monitor, sampled on the falling edge.
  logic [31:0] beatData [0:1023];
  logic        beatLast [0:1023];
  int          beatCount;
  int          lastCount;
  int          initTxCount;
  int          stallViol;
  int          stallCycles;
  logic        prevStall;
  logic [31:0] prevData;
  logic        prevLast;
  logic        monClear;

  always @(negedge clk) begin
    if (monClear) begin
      beatCount   <= 0;
      lastCount   <= 0;
      initTxCount <= 0;
      stallViol   <= 0;
      stallCycles <= 0;
      prevStall   <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        beatData[beatCount] <= m_axis_tdata;
        beatLast[beatCount] <= m_axis_tlast;
        beatCount <= beatCount + 1;
        if (m_axis_tlast) lastCount <= lastCount + 1;
      end
      if (initTx) initTxCount <= initTxCount + 1;
      if (prevStall && (!m_axis_tvalid || m_axis_tdata !== prevData || m_axis_tlast !== prevLast))
        stallViol <= stallViol + 1;
      if (m_axis_tvalid && !m_axis_tready) stallCycles <= stallCycles + 1;
      prevStall <= m_axis_tvalid && !m_axis_tready;
      prevData  <= m_axis_tdata;
      prevLast  <= m_axis_tlast;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setupFeed(input int total, input int period);
    feedTotal   = total;
    feedPeriod  = period;
    feedRestart = 1'b1;
    monClear    = 1'b1;
    step(1);
    feedRestart = 1'b0;
    monClear    = 1'b0;
    step(3);
  endtask

  // Leaves the bench in the cycle after start, where initTx must be high.
  task automatic startFrame();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
    step(3);
  endtask

  task automatic checkStream(input string tag);
    int          bad;
    logic [63:0] w;
    bad = 0;
    for (int i = 0; i < NWORDS; i++) begin
      w = 64'(srcWords[i]);
      if (beatData[2*i] !== w[31:0] || beatData[2*i+1] !== w[63:32]) bad++;
      if (beatLast[2*i] !== 1'b0 || beatLast[2*i+1] !== (i == NWORDS - 1)) bad++;
    end
    chk({tag, " beat count"}, 64'(beatCount), 64'd338);
    chk({tag, " data/last mismatches"}, 64'(bad), 64'd0);
    chk({tag, " tlast count"}, 64'(lastCount), 64'd1);
    chk({tag, " initTx pulses"}, 64'(initTxCount), 64'd1);
  endtask

  task automatic checkOutputsZero(input string tag);
    chk({tag, " initTx"}, 64'(initTx), 64'd0);
    chk({tag, " fifo_rdEn"}, 64'(fifo_rdEn), 64'd0);
    chk({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, " tdata"}, 64'(m_axis_tdata), 64'd0);
    chk({tag, " tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " frameCount"}, 64'(frameCount), 64'd0);
    chk({tag, " timeoutErr"}, 64'(timeoutErr), 64'd0);
  endtask

  initial begin
    int n;
    testsRun      = 0;
    testsFailed   = 0;
    rst           = 1'b1;
    start         = 1'b0;
    m_axis_tready = 1'b1;
    feedTotal     = 0;
    feedPeriod    = 1;
    feedRestart   = 1'b0;
    monClear      = 1'b1;
    cyc           = 0;
    for (int i = 0; i < 256; i++) srcWords[i] = W'(i);
    step(3);
    checkOutputsZero("reset");
    rst      = 1'b0;
    monClear = 1'b0;
    step(1);

    // Frame A: preloaded FIFO, tready high, a second start mid-frame.
    setupFeed(NWORDS, 1);
    startFrame();
    chk("A initTx after start", 64'(initTx), 64'd1);
    chk("A busy after start", 64'(busy), 64'd1);
    step(1);
    chk("A initTx single pulse", 64'(initTx), 64'd0);
    step(100);
    startFrame();
    waitIdle(3000, "A frame completes");
    checkStream("A");
    chk("A frameCount", 64'(frameCount), 64'd1);
    chk("A timeoutErr", 64'(timeoutErr), 64'd0);

    // Frame B: all-ones first word, cycle-exact latency of the first beat.
    srcWords[0] = '1;
    setupFeed(NWORDS, 1);
    startFrame();
    step(2);
    chk("B fifo_rdEn latency", 64'(fifo_rdEn), 64'd1);
    step(1);
    chk("B tvalid latency", 64'(m_axis_tvalid), 64'd1);
    chk("B first LO tdata", 64'(m_axis_tdata), 64'hFFFF_FFFF);
    waitIdle(3000, "B frame completes");
    chk("B wide LO beat", 64'(beatData[0]), 64'hFFFF_FFFF);
    chk("B wide HI beat", 64'(beatData[1]), 64'h001F_FFFF);
    checkStream("B");
    chk("B frameCount", 64'(frameCount), 64'd2);
    srcWords[0] = '0;

    // Frame C: producer at one word per 2 cycles, random backpressure.
    setupFeed(NWORDS, 2);
    startFrame();
    n = 0;
    while (busy && n < 8000) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      step(1);
      n++;
    end
    m_axis_tready = 1'b1;
    chk("C frame completes", 64'(n < 8000), 64'd1);
    step(3);
    checkStream("C");
    chk("C stall stability violations", 64'(stallViol), 64'd0);
    chk("C saw stalls", 64'(stallCycles > 0), 64'd1);
    chk("C frameCount", 64'(frameCount), 64'd3);
    chk("C timeoutErr", 64'(timeoutErr), 64'd0);

    // Timeout: only 10 words ever arrive.
    setupFeed(10, 1);
    startFrame();
    waitIdle(6000, "T abort reaches idle");
    chk("T timeoutErr", 64'(timeoutErr), 64'd1);
    chk("T busy", 64'(busy), 64'd0);
    chk("T beats", 64'(beatCount), 64'd20);
    chk("T no tlast", 64'(lastCount), 64'd0);
    chk("T frameCount unchanged", 64'(frameCount), 64'd3);
    startFrame();
    chk("T start clears timeoutErr", 64'(timeoutErr), 64'd0);
    chk("T restart initTx", 64'(initTx), 64'd1);

    // Reset while HI is stalled with tvalid high.
    m_axis_tready = 1'b0;
    setupFeed(NWORDS, 1);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      step(1);
      n++;
    end
    chk("R reached LO", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    step(1);
    m_axis_tready = 1'b0;
    step(1);
    chk("R HI tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("R HI tdata", 64'(m_axis_tdata), 64'd0);
    rst      = 1'b1;
    monClear = 1'b1;
    step(1);
    checkOutputsZero("R after rst");
    rst           = 1'b0;
    monClear      = 1'b0;
    m_axis_tready = 1'b1;
    step(3);
    startFrame();
    waitIdle(3000, "D frame completes");
    checkStream("D");
    chk("D frameCount", 64'(frameCount), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
